ex_issue_scheduler: RTL and testbench

//  Picks up to two ready reservation-buffer entries per cycle and issues them to EX lanes 0/1.

---
 rtl/ex_issue_scheduler.sv | 126 ++++++++++++
 tb/tb_ex_issue_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_issue_scheduler.sv
// Dual-lane issue picker, oldest-first from rr_ptr, one BRANCH per cycle, per-lane divider occupancy.
// Zero-latency grants; stall/flush suppress issue. Optional perf counters under SCHED_PERF_CNT_EN.
// Unit encoding on req_unit: ALU=0, BRANCH=1, MUL=2, DIV=3, LOAD=4.
module ex_issue_scheduler #(
    parameter int N_ENTRY = 8,
    parameter int DIV_LAT = 4,
    localparam int IW = $clog2(N_ENTRY)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_ENTRY-1:0]          req_valid,
    input  logic [N_ENTRY-1:0][2:0]     req_unit,
    input  logic                        stall,
    input  logic                        flush,
    output logic [1:0]                  grant_valid,
    output logic [1:0][IW-1:0]          grant_idx,
    output logic [1:0]                  lane_busy,
    output logic [IW-1:0]               rr_ptr
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]                 perf_issued,
    output logic [31:0]                 perf_busy_block
`endif
);

    localparam logic [2:0] U_BRANCH = 3'd1;
    localparam logic [2:0] U_DIV    = 3'd3;
    localparam int CW = $clog2(DIV_LAT + 1);

    logic [1:0][CW-1:0] div_cnt;
    logic               pick0_vld, pick1_vld;
    logic [IW-1:0]      pick0_idx, pick1_idx, scan_idx, youngest_idx;
    logic               br_taken;
    logic [1:0]         n_need, n_pick;
    logic               issue_ok;

    always_comb begin
        for (int l = 0; l < 2; l++) begin
            lane_busy[l] = (div_cnt[l] != '0);
        end
    end

    // Only as many picks as free lanes, so a branch past the last pick never consumes the branch slot.
    always_comb begin
        pick0_vld = 1'b0;
        pick1_vld = 1'b0;
        pick0_idx = '0;
        pick1_idx = '0;
        scan_idx  = '0;
        br_taken  = 1'b0;
        n_pick    = 2'd0;
        n_need    = {1'b0, ~lane_busy[0]} + {1'b0, ~lane_busy[1]};
        for (int k = 0; k < N_ENTRY; k++) begin
            scan_idx = rr_ptr + IW'(k);
            if (n_pick < n_need && req_valid[scan_idx] &&
                !(br_taken && req_unit[scan_idx] == U_BRANCH)) begin
                if (n_pick == 2'd0) begin
                    pick0_vld = 1'b1;
                    pick0_idx = scan_idx;
                end else begin
                    pick1_vld = 1'b1;
                    pick1_idx = scan_idx;
                end
                if (req_unit[scan_idx] == U_BRANCH) begin
                    br_taken = 1'b1;
                end
                n_pick = n_pick + 2'd1;
            end
        end
    end

    always_comb begin
        issue_ok    = rst_n && !stall && !flush;
        grant_valid = '0;
        grant_idx   = '0;
        if (issue_ok) begin
            if (!lane_busy[0]) begin
                grant_valid[0] = pick0_vld;
                grant_idx[0]   = pick0_idx;
                grant_valid[1] = pick1_vld;
                grant_idx[1]   = pick1_idx;
            end else begin
                grant_valid[1] = pick0_vld;
                grant_idx[1]   = pick0_idx;
            end
        end
        // Lane 1 always carries the younger pick when both lanes issue.
        youngest_idx = grant_valid[1] ? grant_idx[1] : grant_idx[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            rr_ptr  <= '0;
        end else if (flush) begin
            div_cnt <= '0;
            rr_ptr  <= '0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (grant_valid[l] && req_unit[grant_idx[l]] == U_DIV) begin
                    div_cnt[l] <= CW'(DIV_LAT - 1);
                end else if (div_cnt[l] != '0) begin
                    div_cnt[l] <= div_cnt[l] - CW'(1);
                end
            end
            if (|grant_valid) begin
                rr_ptr <= youngest_idx + IW'(1);
            end
        end
    end

`ifdef SCHED_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued     <= '0;
            perf_busy_block <= '0;
        end else begin
            perf_issued <= perf_issued + {31'd0, grant_valid[0]} + {31'd0, grant_valid[1]};
            if (|req_valid && !stall && !flush && |lane_busy) begin
                perf_busy_block <= perf_busy_block + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ex_issue_scheduler.sv
// Bench for ex_issue_scheduler (N_ENTRY=8, DIV_LAT=4): directed scenarios plus randomized traffic vs a queue-based model.
module tb_ex_issue_scheduler;

    localparam int NE = 8;
    localparam int DL = 4;
    localparam logic [2:0] U_ALU = 3'd0, U_BR = 3'd1, U_DIV = 3'd3;

    logic             clk;
    logic             rst_n;
    logic [NE-1:0]    rv;
    logic [NE-1:0][2:0] ru;
    logic             st, fl;
    logic [1:0]       gv;
    logic [1:0][2:0]  gi;
    logic [1:0]       busy;
    logic [2:0]       ptr;
`ifdef SCHED_PERF_CNT_EN
    logic [31:0]      perf_issued, perf_busy_block;
`endif

    ex_issue_scheduler #(.N_ENTRY(NE), .DIV_LAT(DL)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(rv), .req_unit(ru),
        .stall(st), .flush(fl), .grant_valid(gv), .grant_idx(gi),
        .lane_busy(busy), .rr_ptr(ptr)
`ifdef SCHED_PERF_CNT_EN
        , .perf_issued(perf_issued), .perf_busy_block(perf_busy_block)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: pointer, and the first cycle at which each lane is free again.
    int cyc = 0;
    int m_ptr = 0;
    int m_free_at[2] = '{0, 0};
    logic [1:0] e_gv;
    int e_gi[2];
    logic [1:0] e_busy;
    int e_ptr;
    int e_last;

    function automatic void m_eval();
        int q[$];
        int lanes[$];
        bit br;
        br = 0;
        e_gv = 2'b00;
        e_gi = '{0, 0};
        e_last = 0;
        e_ptr = m_ptr;
        for (int l = 0; l < 2; l++) e_busy[l] = (cyc < m_free_at[l]);
        for (int k = 0; k < NE; k++) begin
            int i;
            i = (m_ptr + k) % NE;
            if (rv[i]) begin
                if (ru[i] == U_BR) begin
                    if (!br) begin
                        br = 1;
                        q.push_back(i);
                    end
                end else begin
                    q.push_back(i);
                end
            end
        end
        if (rst_n && !st && !fl)
            for (int l = 0; l < 2; l++) if (!e_busy[l]) lanes.push_back(l);
        for (int j = 0; j < lanes.size() && j < q.size(); j++) begin
            e_gv[lanes[j]] = 1'b1;
            e_gi[lanes[j]] = q[j];
            e_last = q[j];
        end
    endfunction

    function automatic void m_reset();
        m_ptr = 0;
        m_free_at = '{0, 0};
    endfunction

    task automatic adv();
        @(posedge clk);
        if (!rst_n || fl) begin
            m_reset();
        end else begin
            for (int l = 0; l < 2; l++)
                if (e_gv[l] && ru[e_gi[l]] == U_DIV) m_free_at[l] = cyc + DL;
            if (|e_gv) m_ptr = (e_last + 1) % NE;
        end
        cyc++;
        #1;
    endtask

    task automatic set_all(input logic [NE-1:0] v, input logic [2:0] u);
        rv = v;
        for (int i = 0; i < NE; i++) ru[i] = u;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; st = 0; fl = 0;
        set_all(8'hFF, U_DIV);
        m_reset();
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            m_eval();
            n_cmp++;
            if ({gv, busy, ptr} !== 7'b0) begin
                n_bad++;
                $display("FAIL reset_state: got gv=%b busy=%b ptr=%0d, want all 0", gv, busy, ptr);
            end
            n_cmp++;
            if ({gv, gi, busy, ptr} !== {e_gv, 3'(e_gi[1]), 3'(e_gi[0]), e_busy, 3'(e_ptr)}) begin
                n_bad++;
                $display("FAIL reset_model: got gv=%b gi=%0d/%0d busy=%b ptr=%0d", gv, gi[0], gi[1], busy, ptr);
            end
            adv();
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan_wrap();
        logic [NE-1:0] pat[2] = '{8'b0010_0100, 8'b1000_0011};
        logic [2:0] want[2][3] = '{'{3'd2, 3'd5, 3'd6}, '{3'd7, 3'd0, 3'd1}};
        for (int c = 0; c < 2; c++) begin
            set_all(pat[c], U_ALU);
            @(negedge clk);
            m_eval();
            n_cmp++;
            if (gv !== 2'b11 || gi[0] !== want[c][0] || gi[1] !== want[c][1]) begin
                n_bad++;
                $display("FAIL scan_wrap%0d: got gv=%b idx %0d/%0d, want 11 idx %0d/%0d",
                         c, gv, gi[0], gi[1], want[c][0], want[c][1]);
            end
            adv();
            n_cmp++;
            if (ptr !== want[c][2]) begin
                n_bad++;
                $display("FAIL scan_wrap_ptr%0d: got %0d want %0d", c, ptr, want[c][2]);
            end
        end
    endtask

    task automatic test_branch();
        fl = 1; set_all(8'h00, U_ALU);
        @(negedge clk); m_eval(); adv();
        fl = 0;
        rv = 8'b0000_1110; ru[1] = U_BR; ru[2] = U_BR; ru[3] = U_ALU;
        @(negedge clk);
        m_eval();
        n_cmp++;
        if (gv !== 2'b11 || gi[0] !== 3'd1 || gi[1] !== 3'd3) begin
            n_bad++;
            $display("FAIL branch_skip: got gv=%b idx %0d/%0d, want 11 idx 1/3", gv, gi[0], gi[1]);
        end
        adv();
        rv = 8'b0000_0100;
        @(negedge clk);
        m_eval();
        n_cmp++;
        if (gv !== 2'b01 || gi[0] !== 3'd2) begin
            n_bad++;
            $display("FAIL branch_next: got gv=%b idx %0d, want 01 idx 2", gv, gi[0]);
        end
        adv();
    endtask

    task automatic test_div_lane();
        fl = 1; set_all(8'h00, U_ALU);
        @(negedge clk); m_eval(); adv();
        fl = 0;
        set_all(8'h01, U_ALU); ru[0] = U_DIV;
        @(negedge clk); m_eval(); adv();
        set_all(8'h0E, U_ALU);
        for (int c = 1; c <= DL; c++) begin
            @(negedge clk);
            m_eval();
            n_cmp++;
            if (c < DL && (busy !== 2'b01 || gv !== 2'b10)) begin
                n_bad++;
                $display("FAIL div_busy_t%0d: got busy=%b gv=%b, want 01/10", c, busy, gv);
            end else if (c == DL && (busy !== 2'b00 || gv !== 2'b11)) begin
                n_bad++;
                $display("FAIL div_release: got busy=%b gv=%b, want 00/11", busy, gv);
            end
            n_cmp++;
            if ({gv, gi, busy, ptr} !== {e_gv, 3'(e_gi[1]), 3'(e_gi[0]), e_busy, 3'(e_ptr)}) begin
                n_bad++;
                $display("FAIL div_model_t%0d: got gv=%b gi=%0d/%0d busy=%b ptr=%0d", c, gv, gi[0], gi[1], busy, ptr);
            end
            adv();
        end
    endtask

    task automatic test_flush();
        set_all(8'h03, U_DIV);
        @(negedge clk); m_eval(); adv();
        set_all(8'hFF, U_ALU); fl = 1;
        @(negedge clk);
        m_eval();
        n_cmp++;
        if (busy !== 2'b11 || gv !== 2'b00) begin
            n_bad++;
            $display("FAIL flush_grant: got busy=%b gv=%b, want 11/00", busy, gv);
        end
        adv();
        fl = 0; rv = 8'h00;
        @(negedge clk);
        m_eval();
        n_cmp++;
        if (busy !== 2'b00 || ptr !== 3'd0) begin
            n_bad++;
            $display("FAIL flush_clear: got busy=%b ptr=%0d, want 00/0", busy, ptr);
        end
        adv();
    endtask

    task automatic test_reset_mid_div();
        set_all(8'h01, U_ALU); ru[0] = U_DIV;
        @(negedge clk); m_eval(); adv();
        rv = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({gv, busy, ptr} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_mid_div: got gv=%b busy=%b ptr=%0d, want all 0", gv, busy, ptr);
        end
        @(negedge clk); m_eval(); adv();
        rst_n = 1'b1;
        @(negedge clk);
        m_eval();
        n_cmp++;
        if (busy !== 2'b00) begin
            n_bad++;
            $display("FAIL reset_residual: got busy=%b want 00", busy);
        end
        adv();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rv = NE'($urandom);
            for (int i = 0; i < NE; i++) ru[i] = 3'($urandom_range(0, 4));
            st = ($urandom_range(0, 9) == 0);
            fl = ($urandom_range(0, 24) == 0);
            @(negedge clk);
            m_eval();
            n_cmp++;
            if ({gv, gi} !== {e_gv, 3'(e_gi[1]), 3'(e_gi[0])}) begin
                n_bad++;
                $display("FAIL rand_grant c%0d: got gv=%b gi=%0d/%0d want gv=%b gi=%0d/%0d",
                         c, gv, gi[0], gi[1], e_gv, e_gi[0], e_gi[1]);
            end
            n_cmp++;
            if ({busy, ptr} !== {e_busy, 3'(e_ptr)}) begin
                n_bad++;
                $display("FAIL rand_state c%0d: got busy=%b ptr=%0d want busy=%b ptr=%0d",
                         c, busy, ptr, e_busy, e_ptr);
            end
            adv();
        end
        st = 0; fl = 0;
    endtask

    initial begin
        test_reset();
        test_scan_wrap();
        test_branch();
        test_div_lane();
        test_flush();
        test_reset_mid_div();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
